// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, functs,
// FSM states, instruction classes and datapath select codes.
package mips_ctrl_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_BEQ   = 6'h04,
        OP_BGTZ  = 6'h07,
        OP_ADDIU = 6'h09,
        OP_SLTI  = 6'h0A,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_LB    = 6'h20,
        OP_LW    = 6'h23,
        OP_SB    = 6'h28,
        OP_SW    = 6'h2B
    } opcode_t;

    typedef enum logic [5:0] {
        FN_JR   = 6'h08,
        FN_ADDU = 6'h21,
        FN_AND  = 6'h24,
        FN_OR   = 6'h25,
        FN_SLT  = 6'h2A
    } funct_t;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC_1 = 3'd2,
        S_EXEC_2 = 3'd3,
        S_EXEC_3 = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CLS_RTYPE,
        CLS_JR,
        CLS_IMM,
        CLS_LOAD,
        CLS_STORE,
        CLS_BEQ,
        CLS_BGTZ,
        CLS_J,
        CLS_ILLEGAL
    } instr_class_t;

    // ALU operation codes (4 significant bits)
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // ALU B-operand select
    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REGA   = 2'b11;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational instruction classifier: opcode/funct -> class, legality,
// ALU operation, immediate extension and byte-access flag.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [31:0]  instr,
    output instr_class_t instr_class,
    output logic         legal,
    output logic [3:0]   alu_op,
    output logic         zext,
    output logic         byte_sel
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rt;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign rt     = instr[20:16];

    // Operand fields are consumed by the datapath, not by the control unit.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[25:21], instr[15:6]};

    // Classify the instruction; anything unrecognised stays CLS_ILLEGAL.
    always_comb begin
        instr_class = CLS_ILLEGAL;
        alu_op      = ALU_ADD;
        zext        = 1'b0;
        byte_sel    = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: begin instr_class = CLS_RTYPE; alu_op = ALU_ADD; end
                    FN_AND:  begin instr_class = CLS_RTYPE; alu_op = ALU_AND; end
                    FN_OR:   begin instr_class = CLS_RTYPE; alu_op = ALU_OR;  end
                    FN_SLT:  begin instr_class = CLS_RTYPE; alu_op = ALU_SLT; end
                    FN_JR:   instr_class = CLS_JR;
                    default: instr_class = CLS_ILLEGAL;
                endcase
            end
            OP_J:     instr_class = CLS_J;
            OP_BEQ:   begin instr_class = CLS_BEQ; alu_op = ALU_SUB; end
            // BGTZ compares regA against $0, so rt must encode register 0.
            OP_BGTZ:  begin
                if (rt == 5'd0) instr_class = CLS_BGTZ;
                alu_op = ALU_SUB;
            end
            OP_ADDIU: begin instr_class = CLS_IMM; alu_op = ALU_ADD; end
            OP_SLTI:  begin instr_class = CLS_IMM; alu_op = ALU_SLT; end
            OP_ANDI:  begin instr_class = CLS_IMM; alu_op = ALU_AND; zext = 1'b1; end
            OP_ORI:   begin instr_class = CLS_IMM; alu_op = ALU_OR;  zext = 1'b1; end
            OP_LB:    begin instr_class = CLS_LOAD;  byte_sel = 1'b1; end
            OP_LW:    instr_class = CLS_LOAD;
            OP_SB:    begin instr_class = CLS_STORE; byte_sel = 1'b1; end
            OP_SW:    instr_class = CLS_STORE;
            default:  instr_class = CLS_ILLEGAL;
        endcase
    end

    assign legal = (instr_class != CLS_ILLEGAL);

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM: FETCH/DECODE/EXEC sequencing with a
// variable-latency memory handshake and halt on a jump to address 0.
module mips_mc_control
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_W   = 4,
    parameter int MEM_STALL = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        instr,
    input  logic               waitrequest,
    input  logic               pc_is_zero,
    input  logic               alu_zero,
    input  logic               alu_neg,
    output logic               active,
    output logic               ir_write,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               iord,
    output logic               alu_src_a,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic [1:0]         alu_src_b,
    output logic               zext,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         pc_src,
    output logic [3:0]         byte_en,
    output logic               byte_sel,
    output logic [2:0]         state_out
);

    state_t       state_reg, state_next;
    instr_class_t dec_class;
    logic         dec_legal;
    logic [3:0]   dec_alu_op;
    logic         dec_zext;
    logic         dec_byte_sel;
    logic [3:0]   alu_op4;
    logic         stall;

    mips_ctrl_decode u_decode (
        .instr       (instr),
        .instr_class (dec_class),
        .legal       (dec_legal),
        .alu_op      (dec_alu_op),
        .zext        (dec_zext),
        .byte_sel    (dec_byte_sel)
    );

    // With MEM_STALL=0 memory is single-cycle and waitrequest is ignored.
    assign stall = (MEM_STALL != 0) && waitrequest;

    // State register; reset returns to FETCH and aborts any access in flight.
    always_ff @(posedge clk) begin
        if (reset) state_reg <= S_FETCH;
        else       state_reg <= state_next;
    end

    // Next-state and datapath controls; everything defaults to 0.
    always_comb begin
        state_next    = state_reg;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        alu_src_a     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        alu_src_b     = SRCB_REGB;
        zext          = 1'b0;
        alu_op4       = ALU_AND;
        pc_src        = PCSRC_ALU;
        byte_sel      = 1'b0;
        active        = !reset && (state_reg != S_HALTED);
        if (!reset) begin
            case (state_reg)
                S_FETCH: begin
                    if (pc_is_zero) begin
                        state_next = S_HALTED;
                    end else begin
                        mem_read = 1'b1;
                        if (!stall) begin
                            ir_write   = 1'b1;
                            pc_write   = 1'b1;
                            alu_src_b  = SRCB_FOUR;
                            alu_op4    = ALU_ADD;
                            state_next = S_DECODE;
                        end
                    end
                end
                S_DECODE: begin
                    // Speculatively compute the branch target into ALUOut.
                    alu_src_b  = SRCB_IMM_SH2;
                    alu_op4    = ALU_ADD;
                    state_next = dec_legal ? S_EXEC_1 : S_HALTED;
                end
                S_EXEC_1: begin
                    state_next = S_EXEC_2;
                    case (dec_class)
                        CLS_RTYPE: begin
                            alu_src_a = 1'b1;
                            alu_op4   = dec_alu_op;
                        end
                        CLS_IMM: begin
                            alu_src_a = 1'b1;
                            alu_src_b = SRCB_IMM;
                            zext      = dec_zext;
                            alu_op4   = dec_alu_op;
                        end
                        CLS_LOAD, CLS_STORE: begin
                            alu_src_a = 1'b1;
                            alu_src_b = SRCB_IMM;
                            alu_op4   = ALU_ADD;
                        end
                        CLS_BEQ, CLS_BGTZ: begin
                            alu_src_a     = 1'b1;
                            alu_op4       = ALU_SUB;
                            pc_src        = PCSRC_ALUOUT;
                            pc_write_cond = (dec_class == CLS_BEQ) ? alu_zero
                                                                   : (!alu_zero && !alu_neg);
                            state_next    = S_FETCH;
                        end
                        CLS_J: begin
                            pc_src     = PCSRC_JUMP;
                            pc_write   = 1'b1;
                            state_next = S_FETCH;
                        end
                        CLS_JR: begin
                            pc_src     = PCSRC_REGA;
                            pc_write   = 1'b1;
                            state_next = S_FETCH;
                        end
                        default: state_next = S_HALTED;
                    endcase
                end
                S_EXEC_2: begin
                    state_next = S_FETCH;
                    case (dec_class)
                        CLS_RTYPE: begin
                            reg_dst   = 1'b1;
                            reg_write = 1'b1;
                        end
                        CLS_IMM: reg_write = 1'b1;
                        CLS_LOAD: begin
                            mem_read   = 1'b1;
                            iord       = 1'b1;
                            byte_sel   = dec_byte_sel;
                            state_next = stall ? S_EXEC_2 : S_EXEC_3;
                        end
                        CLS_STORE: begin
                            mem_write  = 1'b1;
                            iord       = 1'b1;
                            byte_sel   = dec_byte_sel;
                            state_next = stall ? S_EXEC_2 : S_FETCH;
                        end
                        default: state_next = S_FETCH;
                    endcase
                end
                S_EXEC_3: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                    state_next = S_FETCH;
                end
                S_HALTED: state_next = S_HALTED;
                default:  state_next = S_HALTED;
            endcase
        end
    end

    // Word accesses enable all lanes; byte accesses leave lane choice to the datapath.
    assign byte_en   = ((mem_read || mem_write) && !byte_sel) ? 4'b1111 : 4'b0000;
    assign alu_op    = ALUOP_W'(alu_op4);
    assign state_out = reset ? 3'd0 : state_reg;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed, table-driven bench for mips_mc_control with hand-written
// sequences for byte loads and the single-cycle memory build.
module tb_mips_mc_control;

    logic        clk = 1'b0;
    logic        reset, reset_b;
    logic [31:0] instr;
    logic        waitrequest, pc_is_zero, alu_zero, alu_neg;

    logic active_a, ir_write_a, pc_write_a, pc_write_cond_a, iord_a, alu_src_a_a;
    logic reg_dst_a, mem_to_reg_a, reg_write_a, mem_read_a, mem_write_a, zext_a, byte_sel_a;
    logic [1:0] alu_src_b_a, pc_src_a;
    logic [3:0] alu_op_a, byte_en_a;
    logic [2:0] state_out_a;

    logic active_b, ir_write_b, pc_write_b, pc_write_cond_b, iord_b, alu_src_a_b;
    logic reg_dst_b, mem_to_reg_b, reg_write_b, mem_read_b, mem_write_b, zext_b, byte_sel_b;
    logic [1:0] alu_src_b_b, pc_src_b;
    logic [3:0] alu_op_b, byte_en_b;
    logic [2:0] state_out_b;

    always #5 clk = ~clk;

    mips_mc_control #(.ALUOP_W(4), .MEM_STALL(1)) dut_a (
        .clk(clk), .reset(reset), .instr(instr), .waitrequest(waitrequest),
        .pc_is_zero(pc_is_zero), .alu_zero(alu_zero), .alu_neg(alu_neg),
        .active(active_a), .ir_write(ir_write_a), .pc_write(pc_write_a),
        .pc_write_cond(pc_write_cond_a), .iord(iord_a), .alu_src_a(alu_src_a_a),
        .reg_dst(reg_dst_a), .mem_to_reg(mem_to_reg_a), .reg_write(reg_write_a),
        .mem_read(mem_read_a), .mem_write(mem_write_a), .alu_src_b(alu_src_b_a),
        .zext(zext_a), .alu_op(alu_op_a), .pc_src(pc_src_a), .byte_en(byte_en_a),
        .byte_sel(byte_sel_a), .state_out(state_out_a)
    );

    mips_mc_control #(.ALUOP_W(4), .MEM_STALL(0)) dut_b (
        .clk(clk), .reset(reset_b), .instr(instr), .waitrequest(1'b1),
        .pc_is_zero(pc_is_zero), .alu_zero(alu_zero), .alu_neg(alu_neg),
        .active(active_b), .ir_write(ir_write_b), .pc_write(pc_write_b),
        .pc_write_cond(pc_write_cond_b), .iord(iord_b), .alu_src_a(alu_src_a_b),
        .reg_dst(reg_dst_b), .mem_to_reg(mem_to_reg_b), .reg_write(reg_write_b),
        .mem_read(mem_read_b), .mem_write(mem_write_b), .alu_src_b(alu_src_b_b),
        .zext(zext_b), .alu_op(alu_op_b), .pc_src(pc_src_b), .byte_en(byte_en_b),
        .byte_sel(byte_sel_b), .state_out(state_out_b)
    );

    logic [24:0] out_a, out_b;
    assign out_a = {active_a, ir_write_a, pc_write_a, pc_write_cond_a, iord_a, alu_src_a_a,
                    reg_dst_a, mem_to_reg_a, reg_write_a, mem_read_a, mem_write_a, zext_a,
                    byte_sel_a, alu_src_b_a, pc_src_a, alu_op_a, byte_en_a};
    assign out_b = {active_b, ir_write_b, pc_write_b, pc_write_cond_b, iord_b, alu_src_a_b,
                    reg_dst_b, mem_to_reg_b, reg_write_b, mem_read_b, mem_write_b, zext_b,
                    byte_sel_b, alu_src_b_b, pc_src_b, alu_op_b, byte_en_b};

    // Bit masks matching the out_a/out_b packing above
    localparam logic [24:0] O_ACT  = 25'd1 << 24;
    localparam logic [24:0] O_IRW  = 25'd1 << 23;
    localparam logic [24:0] O_PCW  = 25'd1 << 22;
    localparam logic [24:0] O_PWC  = 25'd1 << 21;
    localparam logic [24:0] O_IORD = 25'd1 << 20;
    localparam logic [24:0] O_SRCA = 25'd1 << 19;
    localparam logic [24:0] O_RDST = 25'd1 << 18;
    localparam logic [24:0] O_M2R  = 25'd1 << 17;
    localparam logic [24:0] O_RW   = 25'd1 << 16;
    localparam logic [24:0] O_MRD  = 25'd1 << 15;
    localparam logic [24:0] O_MWR  = 25'd1 << 14;
    localparam logic [24:0] O_ZEXT = 25'd1 << 13;
    localparam logic [24:0] O_BSEL = 25'd1 << 12;
    localparam logic [24:0] O_SB4  = 25'd1 << 10;
    localparam logic [24:0] O_SBIM = 25'd2 << 10;
    localparam logic [24:0] O_SBSH = 25'd3 << 10;
    localparam logic [24:0] O_PCAO = 25'd1 << 8;
    localparam logic [24:0] O_PCJ  = 25'd2 << 8;
    localparam logic [24:0] O_PCJR = 25'd3 << 8;
    localparam logic [24:0] O_OR   = 25'd1 << 4;
    localparam logic [24:0] O_ADD  = 25'd2 << 4;
    localparam logic [24:0] O_SUB  = 25'd6 << 4;
    localparam logic [24:0] O_BEW  = 25'hF;

    localparam logic [24:0] E_ZERO   = 25'd0;
    localparam logic [24:0] F_GO     = O_ACT | O_IRW | O_PCW | O_MRD | O_BEW | O_SB4 | O_ADD;
    localparam logic [24:0] F_STALL  = O_ACT | O_MRD | O_BEW;
    localparam logic [24:0] DEC      = O_ACT | O_SBSH | O_ADD;
    localparam logic [24:0] R_E1     = O_ACT | O_SRCA | O_ADD;
    localparam logic [24:0] R_E2     = O_ACT | O_RDST | O_RW;
    localparam logic [24:0] LS_E1    = O_ACT | O_SRCA | O_SBIM | O_ADD;
    localparam logic [24:0] LW_E2    = O_ACT | O_MRD | O_IORD | O_BEW;
    localparam logic [24:0] LB_E2    = O_ACT | O_MRD | O_IORD | O_BSEL;
    localparam logic [24:0] LD_E3    = O_ACT | O_M2R | O_RW;
    localparam logic [24:0] BR_E1    = O_ACT | O_SRCA | O_SUB | O_PCAO;
    localparam logic [24:0] ORI_E1   = O_ACT | O_SRCA | O_SBIM | O_ZEXT | O_OR;
    localparam logic [24:0] IMM_E2   = O_ACT | O_RW;
    localparam logic [24:0] SB_E2    = O_ACT | O_MWR | O_IORD | O_BSEL;
    localparam logic [24:0] SW_E2    = O_ACT | O_MWR | O_IORD | O_BEW;
    localparam logic [24:0] J_E1     = O_ACT | O_PCW | O_PCJ;
    localparam logic [24:0] JR_E1    = O_ACT | O_PCW | O_PCJR;

    localparam logic [31:0] I_ADDU = 32'h00221821;  // addu $3,$1,$2
    localparam logic [31:0] I_LW   = 32'h8C220004;  // lw   $2,4($1)
    localparam logic [31:0] I_LB   = 32'h80220000;  // lb   $2,0($1)
    localparam logic [31:0] I_BGTZ = 32'h1C200008;  // bgtz $1,8
    localparam logic [31:0] I_BEQ  = 32'h10220004;  // beq  $1,$2,4
    localparam logic [31:0] I_ORI  = 32'h342200FF;  // ori  $2,$1,0xff
    localparam logic [31:0] I_SB   = 32'hA0220000;  // sb   $2,0($1)
    localparam logic [31:0] I_SW   = 32'hAC220000;  // sw   $2,0($1)
    localparam logic [31:0] I_JR   = 32'h03E00008;  // jr   $31
    localparam logic [31:0] I_J    = 32'h08000040;  // j    0x100
    localparam logic [31:0] I_BAD  = 32'hFC000000;  // opcode 0x3f

    typedef struct {
        string       name;
        logic        rst;
        logic [31:0] ins;
        logic        wr;
        logic        pz;
        logic        az;
        logic        an;
        logic [2:0]  st;
        logic [24:0] ex;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input string nm, input logic r, input logic [31:0] ins,
                       input logic wr, input logic pz, input logic az, input logic an,
                       input logic [2:0] st, input logic [24:0] ex);
        vec_t v;
        v.name = nm; v.rst = r; v.ins = ins; v.wr = wr; v.pz = pz;
        v.az = az; v.an = an; v.st = st; v.ex = ex;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] ins, input logic wr,
                         input logic pz, input logic az, input logic an);
        reset = r; instr = ins; waitrequest = wr;
        pc_is_zero = pz; alu_zero = az; alu_neg = an;
    endtask

    // One cycle on dut_a: drive after the falling edge, sample 1 ns later.
    task automatic step_a(input string nm, input logic r, input logic [31:0] ins,
                          input logic wr, input logic [2:0] st, input logic [24:0] ex);
        @(negedge clk);
        drive(r, ins, wr, 1'b0, 1'b0, 1'b0);
        #1;
        check({nm, " state"}, {29'd0, state_out_a}, {29'd0, st});
        check({nm, " outs"}, {7'd0, out_a}, {7'd0, ex});
        $display("%s: state=%0d outs=%h", nm, state_out_a, out_a);
    endtask

    task automatic step_b(input string nm, input logic rb, input logic [2:0] st,
                          input logic [24:0] ex);
        @(negedge clk);
        reset_b = rb; instr = I_LW;
        #1;
        check({nm, " state"}, {29'd0, state_out_b}, {29'd0, st});
        check({nm, " outs"}, {7'd0, out_b}, {7'd0, ex});
        $display("%s: state=%0d outs=%h", nm, state_out_b, out_b);
    endtask

    initial begin
        reset_b = 1'b1;
        drive(1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        //   name          rst  instr   wr  pz  az  an  st    expected
        add("reset0",     1, I_ADDU, 0, 0, 0, 0, 3'd0, E_ZERO);
        add("reset1",     1, I_ADDU, 0, 0, 0, 0, 3'd0, E_ZERO);
        add("addu F",     0, I_ADDU, 0, 0, 0, 0, 3'd0, F_GO);
        add("addu D",     0, I_ADDU, 0, 0, 0, 0, 3'd1, DEC);
        add("addu E1",    0, I_ADDU, 0, 0, 0, 0, 3'd2, R_E1);
        add("addu E2",    0, I_ADDU, 0, 0, 0, 0, 3'd3, R_E2);
        add("lw Fstall",  0, I_LW,   1, 0, 0, 0, 3'd0, F_STALL);
        add("lw F",       0, I_LW,   0, 0, 0, 0, 3'd0, F_GO);
        add("lw D",       0, I_LW,   0, 0, 0, 0, 3'd1, DEC);
        add("lw E1",      0, I_LW,   0, 0, 0, 0, 3'd2, LS_E1);
        add("lw E2w1",    0, I_LW,   1, 0, 0, 0, 3'd3, LW_E2);
        add("lw E2w2",    0, I_LW,   1, 0, 0, 0, 3'd3, LW_E2);
        add("lw E2",      0, I_LW,   0, 0, 0, 0, 3'd3, LW_E2);
        add("lw E3",      0, I_LW,   0, 0, 0, 0, 3'd4, LD_E3);
        add("bgtz F",     0, I_BGTZ, 0, 0, 0, 0, 3'd0, F_GO);
        add("bgtz D",     0, I_BGTZ, 0, 0, 0, 0, 3'd1, DEC);
        add("bgtz neg",   0, I_BGTZ, 0, 0, 0, 1, 3'd2, BR_E1);
        add("bgtz F2",    0, I_BGTZ, 0, 0, 0, 0, 3'd0, F_GO);
        add("bgtz D2",    0, I_BGTZ, 0, 0, 0, 0, 3'd1, DEC);
        add("bgtz pos",   0, I_BGTZ, 0, 0, 0, 0, 3'd2, BR_E1 | O_PWC);
        add("beq F",      0, I_BEQ,  0, 0, 0, 0, 3'd0, F_GO);
        add("beq D",      0, I_BEQ,  0, 0, 0, 0, 3'd1, DEC);
        add("beq taken",  0, I_BEQ,  0, 0, 1, 0, 3'd2, BR_E1 | O_PWC);
        add("ori F",      0, I_ORI,  0, 0, 0, 0, 3'd0, F_GO);
        add("ori D",      0, I_ORI,  0, 0, 0, 0, 3'd1, DEC);
        add("ori E1",     0, I_ORI,  0, 0, 0, 0, 3'd2, ORI_E1);
        add("ori E2",     0, I_ORI,  0, 0, 0, 0, 3'd3, IMM_E2);
        add("sb F",       0, I_SB,   0, 0, 0, 0, 3'd0, F_GO);
        add("sb D",       0, I_SB,   0, 0, 0, 0, 3'd1, DEC);
        add("sb E1",      0, I_SB,   0, 0, 0, 0, 3'd2, LS_E1);
        add("sb E2",      0, I_SB,   0, 0, 0, 0, 3'd3, SB_E2);
        add("jr F",       0, I_JR,   0, 0, 0, 0, 3'd0, F_GO);
        add("jr D",       0, I_JR,   0, 0, 0, 0, 3'd1, DEC);
        add("jr E1",      0, I_JR,   0, 0, 0, 0, 3'd2, JR_E1);
        add("j F",        0, I_J,    0, 0, 0, 0, 3'd0, F_GO);
        add("j D",        0, I_J,    0, 0, 0, 0, 3'd1, DEC);
        add("j E1",       0, I_J,    0, 0, 0, 0, 3'd2, J_E1);
        add("pc0 F",      0, I_J,    0, 1, 0, 0, 3'd0, O_ACT);
        add("halted",     0, I_J,    0, 0, 0, 0, 3'd5, E_ZERO);
        add("halt hold",  0, I_ADDU, 1, 1, 1, 1, 3'd5, E_ZERO);
        add("halt reset", 1, I_ADDU, 0, 0, 0, 0, 3'd0, E_ZERO);
        add("bad F",      0, I_BAD,  0, 0, 0, 0, 3'd0, F_GO);
        add("bad D",      0, I_BAD,  0, 0, 0, 0, 3'd1, DEC);
        add("bad halt",   0, I_BAD,  0, 0, 0, 0, 3'd5, E_ZERO);
        add("reset2",     1, I_SW,   0, 0, 0, 0, 3'd0, E_ZERO);
        add("sw F",       0, I_SW,   0, 0, 0, 0, 3'd0, F_GO);
        add("sw D",       0, I_SW,   0, 0, 0, 0, 3'd1, DEC);
        add("sw E1",      0, I_SW,   0, 0, 0, 0, 3'd2, LS_E1);
        add("sw E2w",     0, I_SW,   1, 0, 0, 0, 3'd3, SW_E2);
        add("sw abort",   1, I_SW,   1, 0, 0, 0, 3'd0, E_ZERO);
        add("after abrt", 0, I_SW,   0, 0, 0, 0, 3'd0, F_GO);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].ins, vecs[i].wr, vecs[i].pz, vecs[i].az, vecs[i].an);
            #1;
            check({vecs[i].name, " state"}, {29'd0, state_out_a}, {29'd0, vecs[i].st});
            check({vecs[i].name, " outs"}, {7'd0, out_a}, {7'd0, vecs[i].ex});
            $display("vec %0d %s: state=%0d outs=%h", i, vecs[i].name, state_out_a, out_a);
        end

        // Byte load: lane choice is left to the datapath, so byte_en stays 0.
        step_a("lb reset", 1'b1, I_LB, 1'b0, 3'd0, E_ZERO);
        step_a("lb F",     1'b0, I_LB, 1'b0, 3'd0, F_GO);
        step_a("lb D",     1'b0, I_LB, 1'b0, 3'd1, DEC);
        step_a("lb E1",    1'b0, I_LB, 1'b0, 3'd2, LS_E1);
        step_a("lb E2",    1'b0, I_LB, 1'b0, 3'd3, LB_E2);
        step_a("lb E3",    1'b0, I_LB, 1'b0, 3'd4, LD_E3);

        // Single-cycle memory build: waitrequest tied high must not stall.
        step_b("ms0 reset", 1'b1, 3'd0, E_ZERO);
        step_b("ms0 F",     1'b0, 3'd0, F_GO);
        step_b("ms0 D",     1'b0, 3'd1, DEC);
        step_b("ms0 E1",    1'b0, 3'd2, LS_E1);
        step_b("ms0 E2",    1'b0, 3'd3, LW_E2);
        step_b("ms0 E3",    1'b0, 3'd4, LD_E3);
        step_b("ms0 F2",    1'b0, 3'd0, F_GO);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
